gpca_issue_ctrl: RTL and testbench

- Sequencer and credit controller in front of a pipelined 9-row general-purpose cellular array (gpca-style divider/root array).
- The array has one stage register per row, so it accepts one operation per cycle. It has no stall input, and its mode bit X is global to all rows.
- This block accepts tagged requests over a valid/ready handshake, issues them into the array, and tracks in-flight operations with a valid/tag shift register.
- Returned F/S results are captured into a response FIFO sized so it can never overflow. The block drains the pipeline before any change of X.

---
 rtl/gpca_ctrl_defs.sv | 20 ++
 rtl/gpca_rsp_fifo.sv | 62 ++++++
 rtl/gpca_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gpca_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpca_ctrl_defs.sv
// Shared encodings and default geometry for the gpca issue controller slice.
package gpca_ctrl_defs;
  localparam int GPCA_STAGES     = 9;
  localparam int GPCA_AW         = 18;
  localparam int GPCA_BW         = 19;
  localparam int GPCA_QW         = 9;
  localparam int GPCA_TW         = 4;
  localparam int GPCA_FIFO_DEPTH = 12;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gpca_rsp_fifo.sv
// Synchronous response FIFO; depth need not be a power of two.
module gpca_rsp_fifo
  import gpca_ctrl_defs::*;
#(
  parameter int DEPTH = GPCA_FIFO_DEPTH,
  parameter int W     = 33,
  localparam int PW   = idx_w(DEPTH),
  localparam int CW   = idx_w(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (cnt_q == '0);
  assign pop_ok = pop && !empty;
  assign dout   = mem_q[rd_q];
  assign count  = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = nxt(wr_q);
    end
    if (pop_ok) rd_d = nxt(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop_ok);
  end

  // Storage is cleared too so the response payload reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/gpca_issue_ctrl.sv
// Issue sequencer and credit tracker for the pipelined gpca array; drains the
// array before every change of the global X mode.
module gpca_issue_ctrl
  import gpca_ctrl_defs::*;
#(
  parameter int STAGES     = GPCA_STAGES,
  parameter int AW         = GPCA_AW,
  parameter int BW         = GPCA_BW,
  parameter int QW         = GPCA_QW,
  parameter int TW         = GPCA_TW,
  parameter int FIFO_DEPTH = GPCA_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_x,
  input  logic [AW-1:0] req_a,
  input  logic [BW-1:0] req_b,
  input  logic [BW-1:0] req_c,
  input  logic [QW-1:0] req_p,
  input  logic [TW-1:0] req_tag,
  output logic          arr_issue,
  output logic          arr_x,
  output logic [AW-1:0] arr_a,
  output logic [BW-1:0] arr_b,
  output logic [BW-1:0] arr_c,
  output logic [QW-1:0] arr_p,
  input  logic [QW-1:0] arr_res_f,
  input  logic [BW-1:0] arr_res_s,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [QW-1:0] rsp_f,
  output logic [BW-1:0] rsp_s,
  output logic [TW-1:0] rsp_tag,
  output logic          rsp_x,
  output logic          busy
);
  localparam int RW = QW + BW + TW + 1;
  localparam int CW = idx_w(FIFO_DEPTH + 1);
  localparam int IW = idx_w(STAGES + 2);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  state_e                   state_q, state_d;
  logic                     cur_x_q, cur_x_d;
  logic                     pend_x_q, pend_x_d;
  logic                     alive_q;
  logic [STAGES:0]          vld_pipe_q, vld_pipe_d;
  logic [STAGES:0][TW-1:0]  tag_pipe_q, tag_pipe_d;
  logic [STAGES:0]          x_pipe_q, x_pipe_d;
  logic [AW-1:0]            a_q, a_d;
  logic [BW-1:0]            b_q, b_d, c_q, c_d;
  logic [QW-1:0]            p_q, p_d;
  logic [IW-1:0]            inflight_q, inflight_d;

  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty;
  logic [RW-1:0]            fifo_dout;
  logic                     push, pop, accept, credit_ok;
  logic [SW-1:0]            credits_used;

  // Counts are registered, so a credit freed by a pop is usable next cycle.
  assign credits_used = SW'(inflight_q) + SW'(fifo_count);
  assign credit_ok    = credits_used < SW'(FIFO_DEPTH);
  assign req_ready    = alive_q && (state_q == ST_RUN) && (req_x == cur_x_q) && credit_ok;
  assign accept       = req_valid && req_ready;

  // vld_pipe[0] is the issue flop; stage STAGES lines up with the array result.
  assign push      = vld_pipe_q[STAGES];
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign {rsp_f, rsp_s, rsp_tag, rsp_x} = fifo_dout;

  assign arr_issue = vld_pipe_q[0];
  assign arr_x     = cur_x_q;
  assign arr_a     = a_q;
  assign arr_b     = b_q;
  assign arr_c     = c_q;
  assign arr_p     = p_q;
  assign busy      = (state_q != ST_RUN) || (inflight_q != '0) || !fifo_empty;

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    pend_x_d = pend_x_q;
    case (state_q)
      ST_RUN: begin
        if (alive_q && req_valid && (req_x != cur_x_q)) begin
          state_d  = ST_DRAIN;
          pend_x_d = req_x;
        end
      end
      ST_DRAIN:  if (inflight_q == '0) state_d = ST_SWITCH;
      ST_SWITCH: begin
        cur_x_d = pend_x_q;
        state_d = ST_RUN;
      end
      default:   state_d = ST_RUN;
    endcase

    vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept};
    tag_pipe_d = {tag_pipe_q[STAGES-1:0], req_tag};
    x_pipe_d   = {x_pipe_q[STAGES-1:0], cur_x_q};

    a_d = accept ? req_a : a_q;
    b_d = accept ? req_b : b_q;
    c_d = accept ? req_c : c_q;
    p_d = accept ? req_p : p_q;

    inflight_d = inflight_q + IW'(accept) - IW'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cur_x_q    <= 1'b0;
      pend_x_q   <= 1'b0;
      alive_q    <= 1'b0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      x_pipe_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      pend_x_q   <= pend_x_d;
      alive_q    <= 1'b1;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      x_pipe_q   <= x_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      p_q        <= p_d;
      inflight_q <= inflight_d;
    end
  end

  gpca_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({arr_res_f, arr_res_s, tag_pipe_q[STAGES], x_pipe_q[STAGES]}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credits_used <= SW'(FIFO_DEPTH));
  a_x_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (cur_x_d != cur_x_q) |-> (inflight_q == '0));
endmodule

// File: tb/tb_gpca_issue_ctrl.sv
// Directed bench for gpca_issue_ctrl with a behavioural array and a response scoreboard.
module tb_gpca_issue_ctrl;
  localparam int STAGES = 9, AW = 18, BW = 19, QW = 9, TW = 4, DEPTH = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_x = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_a = '0;
  logic [BW-1:0] req_b = '0, req_c = '0;
  logic [QW-1:0] req_p = '0;
  logic [TW-1:0] req_tag = '0;
  logic          req_ready, arr_issue, arr_x, rsp_valid, rsp_x, busy;
  logic [AW-1:0] arr_a;
  logic [BW-1:0] arr_b, arr_c, arr_res_s, rsp_s;
  logic [QW-1:0] arr_p, arr_res_f, rsp_f;
  logic [TW-1:0] rsp_tag;

  gpca_issue_ctrl #(.STAGES(STAGES), .AW(AW), .BW(BW), .QW(QW), .TW(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_p(req_p), .req_tag(req_tag),
    .arr_issue(arr_issue), .arr_x(arr_x), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
    .arr_p(arr_p), .arr_res_f(arr_res_f), .arr_res_s(arr_res_s), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_s(rsp_s), .rsp_tag(rsp_tag), .rsp_x(rsp_x),
    .busy(busy));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array reference function, mode selected by X.
  function automatic logic [QW-1:0] ref_f(input logic x, input logic [AW-1:0] a, input logic [QW-1:0] p);
    return x ? (p ^ a[QW-1:0]) : (p + a[AW-1:AW-QW]);
  endfunction
  function automatic logic [BW-1:0] ref_s(input logic x, input logic [AW-1:0] a,
                                          input logic [BW-1:0] b, input logic [BW-1:0] c);
    return x ? (b - c) : ((b + c) ^ {a, 1'b0});
  endfunction

  // Behavioural array: no reset, result valid STAGES cycles after issue, junk otherwise.
  logic [STAGES-1:0] av = '0;
  logic [QW-1:0] af  [STAGES];
  logic [BW-1:0] asr [STAGES];
  always @(posedge clk) begin
    av     <= {av[STAGES-2:0], arr_issue};
    af[0]  <= ref_f(arr_x, arr_a, arr_p);
    asr[0] <= ref_s(arr_x, arr_a, arr_b, arr_c);
    for (int i = 1; i < STAGES; i++) begin
      af[i]  <= af[i-1];
      asr[i] <= asr[i-1];
    end
  end
  assign arr_res_f = av[STAGES-1] ? af[STAGES-1]  : '1;
  assign arr_res_s = av[STAGES-1] ? asr[STAGES-1] : '1;

  typedef struct packed {
    logic [QW-1:0] f;
    logic [BW-1:0] s;
    logic [TW-1:0] tag;
    logic          x;
  } rsp_t;

  rsp_t sb[$];
  int   acc_cyc[$], pop_cyc[$];
  int   tests = 0, fails = 0, op_id = 0, x_chg_cyc = -1;
  logic prev_x = 1'b0;

  // Scoreboard: push on accept, pop/compare on response handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (req_valid && req_ready) begin
      e.f = ref_f(req_x, req_a, req_p);
      e.s = ref_s(req_x, req_a, req_b, req_c);
      e.tag = req_tag;
      e.x = req_x;
      sb.push_back(e);
      acc_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      pop_cyc.push_back(cyc);
      tests++;
      assert (sb.size() > 0) else begin
        fails++; $error("FAIL rsp_unexpected: got tag %0d, expected no response", rsp_tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        assert ({rsp_f, rsp_s, rsp_tag, rsp_x} === e) else begin
          fails++; $error("FAIL rsp_payload: got 0x%0h, expected 0x%0h", {rsp_f, rsp_s, rsp_tag, rsp_x}, e);
        end
      end
    end
    if (rst_n && (arr_x !== prev_x)) begin
      x_chg_cyc <= cyc;
      tests++;
      assert (av === '0) else begin
        fails++; $error("FAIL x_change_busy: array valid %b, expected 0", av);
      end
    end
    prev_x <= arr_x;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic x);
    req_x   = x;
    req_tag = op_id[TW-1:0];
    req_a   = AW'(op_id * 7919 + 13);
    req_b   = BW'(op_id * 104729 + 5);
    req_c   = BW'(op_id * 31 + 977);
    req_p   = QW'(op_id * 3 + 1);
  endtask

  // Offer ops back to back; ops from index sw onward use the other X.
  task automatic stream(input int nops, input logic x0, input int sw, input int max_cyc,
                        input bit keep, output int n_acc);
    int w;
    w = 0;
    n_acc = 0;
    load_op(x0);
    req_valid = 1'b1;
    while (n_acc < nops && w < max_cyc) begin
      @(negedge clk);
      if (req_ready) begin
        n_acc++;
        op_id++;
      end
      tick();
      w++;
      if (n_acc < nops) load_op(x0 ^ (n_acc >= sw));
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy && w < 300) begin
      tick();
      w++;
    end
    chk(tag, 64'(busy), 64'(0));
  endtask

  task automatic wait_rsp(output int c);
    int w;
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    c = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, c, seen;
    // Reset state, with a request offered during reset.
    req_valid = 1'b1;
    #2;
    chk("reset_ctrl", 64'({req_ready, arr_issue, arr_x, rsp_valid, busy}), 64'(0));
    chk("reset_arr_ab", 64'({arr_a, arr_b}), 64'(0));
    chk("reset_arr_cp", 64'({arr_c, arr_p}), 64'(0));
    chk("reset_rsp", 64'({rsp_f, rsp_s, rsp_tag, rsp_x}), 64'(0));
    req_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single op, tag 3: issue next cycle, response 11 cycles after accept, held until ready.
    op_id = 3;
    acc_cyc.delete();
    stream(1, 1'b0, 99, 20, 1'b0, n);
    chk("t1_accept", 64'(n), 64'(1));
    t0 = acc_cyc[0];
    chk("t1_issue", 64'({arr_issue, arr_x}), 64'(2'b10));
    chk("t1_arr_a", 64'(arr_a), 64'(AW'(3 * 7919 + 13)));
    tick();
    chk("t1_issue_drop", 64'(arr_issue), 64'(0));
    chk("t1_arr_hold", 64'(arr_a), 64'(AW'(3 * 7919 + 13)));
    wait_rsp(c);
    chk("t1_latency", 64'(c - t0), 64'(11));
    tick(2);
    chk("t1_rsp_hold", 64'({rsp_valid, rsp_tag, rsp_x}), 64'({1'b1, 4'd3, 1'b0}));
    rsp_ready = 1'b1;
    wait_idle("t1_idle");

    // 20 ops, same mode, sink always ready.
    op_id = 0;
    acc_cyc.delete();
    pop_cyc.delete();
    stream(20, 1'b0, 99, 40, 1'b0, n);
    chk("t2_accepts", 64'(n), 64'(20));
    chk("t2_no_ready_drop", 64'(acc_cyc[19] - acc_cyc[0]), 64'(19));
    wait_idle("t2_idle");
    chk("t2_rsp_count", 64'(pop_cyc.size()), 64'(20));
    chk("t2_rsp_back2back", 64'(pop_cyc[19] - pop_cyc[0]), 64'(19));
    chk("t2_first_latency", 64'(pop_cyc[0] - acc_cyc[0]), 64'(11));

    // Sink stalled: credits cap acceptance at FIFO depth, resume right after first pop.
    rsp_ready = 1'b0;
    op_id = 0;
    acc_cyc.delete();
    stream(16, 1'b0, 99, 30, 1'b1, n);
    chk("t3_accept_cap", 64'(n), 64'(12));
    chk("t3_ready_low", 64'(req_ready), 64'(0));
    pop_cyc.delete();
    acc_cyc.delete();
    rsp_ready = 1'b1;
    stream(4, 1'b0, 99, 40, 1'b0, n);
    chk("t3_resume_n", 64'(n), 64'(4));
    chk("t3_resume_cyc", 64'(acc_cyc[0] - pop_cyc[0]), 64'(1));
    wait_idle("t3_idle");
    chk("t3_rsp_count", 64'(pop_cyc.size()), 64'(16));

    // One entry in FIFO, pop and push in the same cycle: one entry remains, order kept.
    rsp_ready = 1'b0;
    op_id = 5;
    stream(1, 1'b0, 99, 20, 1'b0, n);
    wait_rsp(c);
    tick();
    acc_cyc.delete();
    stream(1, 1'b0, 99, 20, 1'b0, n);
    tick(9);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_count_kept", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd6}));
    tick();
    chk("t5_hold", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd6}));
    rsp_ready = 1'b1;
    tick();
    chk("t5_single_entry", 64'(rsp_valid), 64'(0));
    wait_idle("t5_idle");

    // Reset with 5 ops in the array and 2 in the FIFO: all discarded.
    rsp_ready = 1'b0;
    op_id = 0;
    stream(7, 1'b0, 99, 20, 1'b0, n);
    chk("t6_accepts", 64'(n), 64'(7));
    tick(5);
    chk("t6_pre", 64'({rsp_valid, busy}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", 64'({req_ready, arr_issue, arr_x, rsp_valid, busy}), 64'(0));
    chk("t6_rst_arr", 64'({arr_a, arr_b}), 64'(0));
    chk("t6_rst_rsp", 64'({rsp_f, rsp_s, rsp_tag, rsp_x}), 64'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'(0));
    rsp_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t6_no_stale_rsp", 64'(seen), 64'(0));
    tick();

    // Mode change: two x=0 ops then an x=1 op; drain, switch, then accept.
    op_id = 0;
    acc_cyc.delete();
    stream(3, 1'b0, 2, 40, 1'b0, n);
    chk("t4_accepts", 64'(n), 64'(3));
    chk("t4_switch_delay", 64'(acc_cyc[2] - acc_cyc[0]), 64'(14));
    chk("t4_x_edge", 64'(x_chg_cyc - acc_cyc[0]), 64'(14));
    wait_idle("t4_idle");
    chk("t4_arr_x", 64'(arr_x), 64'(1));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
